// File: rtl/isp_mode_ctrl.sv
`timescale 1ns/1ps
// isp_mode_ctrl: selects which ISP stage drives the HDMI transmitter and applies mode changes on vsync.
// Latency: an applied mode, the mute and the frame count change one cycle after vsync is first sampled high.
// Backpressure: cfg_ready is low from acceptance of a mode change until its flush frames have passed.
//
// Ports:
//   pixel_clk, sys_rst_n      - the only clock; asynchronous active-low reset
//   in_vsync                  - active-high vsync, synchronous to pixel_clk
//   cfg_mode/cfg_valid        - mode request (0 bypass, 1 demosaic_h, 2 demosaic_m, 3 demosaic_l)
//   cfg_ready                 - request can be accepted (RUN state only)
//   act_mode, stage_en        - applied mode and its one-hot stage enable
//   mute, busy                - force output black; controller not in RUN
//   frame_cnt                 - free-running count of vsync rising edges
//   vs_timeout                - vsync-loss flag
// Build option: define ISP_MODE_CTRL_TIMEOUT_EN to build the vsync watchdog; otherwise
// vs_timeout is tied low and a pending switch waits for vsync indefinitely.
module isp_mode_ctrl #(
  parameter int unsigned RESET_MODE     = 3,
  parameter int unsigned FLUSH_FRAMES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 3000000
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        in_vsync,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [1:0]  act_mode,
  output logic [3:0]  stage_en,
  output logic        mute,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        vs_timeout
);

  localparam logic [1:0]  LP_RESET_MODE = RESET_MODE[1:0];
  localparam logic [3:0]  LP_FLUSH      = FLUSH_FRAMES[3:0];
  localparam logic [21:0] LP_WD_LIMIT   = 22'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [3:0] f_onehot(input logic [1:0] m);
    f_onehot = 4'b0001 << m;
  endfunction

  state_t      r_state;
  logic [3:0]  r_flush_cnt;
  logic [1:0]  r_pend_mode;
  logic [1:0]  r_act_mode;
  logic [3:0]  r_stage_en;
  logic        r_mute;
  logic        r_busy;
  logic        r_cfg_ready;
  logic [15:0] r_frame_cnt;
  logic        r_vs_d;
  logic        w_vs_rise;
  logic        w_vs_timeout;

  assign w_vs_rise = in_vsync & ~r_vs_d;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vs_d <= 1'b0;
    end else begin
      r_vs_d <= in_vsync;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_vs_rise) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef ISP_MODE_CTRL_TIMEOUT_EN
  logic [21:0] r_wd_cnt;
  logic        r_vs_timeout;

  // Counter saturates at the limit; the flag follows one cycle after the limit is registered
  // and holds until vsync returns.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wd_cnt     <= 22'd0;
      r_vs_timeout <= 1'b0;
    end else if (w_vs_rise) begin
      r_wd_cnt     <= 22'd0;
      r_vs_timeout <= 1'b0;
    end else begin
      if (r_wd_cnt != LP_WD_LIMIT) begin
        r_wd_cnt <= r_wd_cnt + 22'd1;
      end
      if (r_wd_cnt == LP_WD_LIMIT) begin
        r_vs_timeout <= 1'b1;
      end
    end
  end

  assign w_vs_timeout = r_vs_timeout;
`else
  logic [21:0] w_unused_wd_limit;
  assign w_unused_wd_limit = LP_WD_LIMIT;
  assign w_vs_timeout      = 1'b0;
`endif

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= LP_FLUSH;
      r_pend_mode <= LP_RESET_MODE;
      r_act_mode  <= LP_RESET_MODE;
      r_stage_en  <= f_onehot(LP_RESET_MODE);
      r_mute      <= 1'b1;
      r_busy      <= 1'b1;
      r_cfg_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // A request for the mode already applied is consumed without disturbing the output.
          if (cfg_valid && r_cfg_ready && (cfg_mode != r_act_mode)) begin
            r_pend_mode <= cfg_mode;
            r_state     <= ST_PEND;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_PEND: begin
          // With vsync lost there is no frame to tear, so the watchdog may apply the switch.
          if (w_vs_rise || w_vs_timeout) begin
            r_act_mode  <= r_pend_mode;
            r_stage_en  <= f_onehot(r_pend_mode);
            r_mute      <= 1'b1;
            r_flush_cnt <= LP_FLUSH;
            r_state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Only real frames refill line buffers, so the watchdog never ends a flush.
          if (w_vs_rise) begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
            if (r_flush_cnt == 4'd1) begin
              r_mute      <= 1'b0;
              r_busy      <= 1'b0;
              r_cfg_ready <= 1'b1;
              r_state     <= ST_RUN;
            end
          end
        end
        default: begin
          r_state     <= ST_FLUSH;
          r_flush_cnt <= LP_FLUSH;
          r_mute      <= 1'b1;
          r_busy      <= 1'b1;
          r_cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign act_mode   = r_act_mode;
  assign stage_en   = r_stage_en;
  assign mute       = r_mute;
  assign busy       = r_busy;
  assign frame_cnt  = r_frame_cnt;
  assign vs_timeout = w_vs_timeout;

endmodule

// File: tb/tb_isp_mode_ctrl.sv
`timescale 1ns/1ps
// tb_isp_mode_ctrl: directed stimulus with a queue of expected output snapshots.
// Latency: each expected snapshot is consumed when the DUT outputs change.
// Backpressure: requests are driven only when the bench expects cfg_ready high.
module tb_isp_mode_ctrl;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_vsync;
  logic [1:0]  cfg_mode;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  act_mode;
  logic [3:0]  stage_en;
  logic        mute;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        vs_timeout;

  always #5 pixel_clk = ~pixel_clk;

  isp_mode_ctrl #(
    .RESET_MODE    (3),
    .FLUSH_FRAMES  (2),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .in_vsync  (in_vsync),
    .cfg_mode  (cfg_mode),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .act_mode  (act_mode),
    .stage_en  (stage_en),
    .mute      (mute),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .vs_timeout(vs_timeout)
  );

  int          checks = 0;
  int          errors = 0;
  logic [25:0] exp_q[$];
  logic [15:0] fc;

  // Snapshot layout: {mode, stage_en, mute, busy, cfg_ready, frame_cnt, vs_timeout}
  function automatic logic [25:0] mk(input logic [1:0] m, input logic mu, input logic bz,
                                     input logic rd, input logic [15:0] f, input logic to);
    logic [3:0] oh;
    oh = 4'b0001 << m;
    return {m, oh, mu, bz, rd, f, to};
  endfunction

  task automatic push(input logic [1:0] m, input logic mu, input logic bz, input logic rd,
                      input logic [15:0] f, input logic to);
    exp_q.push_back(mk(m, mu, bz, rd, f, to));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  // One vsync pulse held high for three cycles; exactly one rising edge is expected.
  task automatic edge_exp(input logic [1:0] m, input logic mu, input logic bz, input logic rd);
    fc = fc + 16'd1;
    push(m, mu, bz, rd, fc, 1'b0);
    in_vsync = 1'b1;
    tick(3);
    in_vsync = 1'b0;
    tick(5);
  endtask

  task automatic req(input logic [1:0] m);
    cfg_mode  = m;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  // Monitor: compares on the first sample after reset and on every output change.
  logic [25:0] prev;
  logic [25:0] obs;
  logic [25:0] ex;
  bit          armed = 1'b0;

  always @(negedge pixel_clk) begin
    if (!sys_rst_n) begin
      armed = 1'b0;
    end else begin
      obs = {act_mode, stage_en, mute, busy, cfg_ready, frame_cnt, vs_timeout};
      if (!armed || obs != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change t=%0t: got mode=%0d en=%b mute=%b busy=%b rdy=%b fcnt=%h tmo=%b, no change required",
                   $time, obs[25:24], obs[23:20], obs[19], obs[18], obs[17], obs[16:1], obs[0]);
        end else begin
          ex = exp_q.pop_front();
          if (obs !== ex) begin
            errors++;
            $display("FAIL out_event t=%0t: got mode=%0d en=%b mute=%b busy=%b rdy=%b fcnt=%h tmo=%b, want mode=%0d en=%b mute=%b busy=%b rdy=%b fcnt=%h tmo=%b",
                     $time, obs[25:24], obs[23:20], obs[19], obs[18], obs[17], obs[16:1], obs[0],
                     ex[25:24], ex[23:20], ex[19], ex[18], ex[17], ex[16:1], ex[0]);
          end
        end
      end
      prev  = obs;
      armed = 1'b1;
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    in_vsync  = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    fc        = 16'd0;

    // Reset state, then flush release on the second edge
    push(2'd3, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(4);
    edge_exp(2'd3, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd3, 1'b0, 1'b0, 1'b1);

    // Mid-frame switch to mode 1: nothing but ready/busy may move before the next edge
    tick(3);
    push(2'd3, 1'b0, 1'b1, 1'b0, fc, 1'b0);
    req(2'd1);
    tick(10);
    edge_exp(2'd1, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd1, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd1, 1'b0, 1'b0, 1'b1);

    // Same-mode request: no output change at all
    req(2'd1);
    tick(10);
    edge_exp(2'd1, 1'b0, 1'b0, 1'b1);

    // Request coincident with an edge, plus an ignored second request during PEND
    fc = fc + 16'd1;
    push(2'd1, 1'b0, 1'b1, 1'b0, fc, 1'b0);
    cfg_mode  = 2'd2;
    cfg_valid = 1'b1;
    in_vsync  = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    tick(2);
    in_vsync = 1'b0;
    tick(5);
    cfg_mode  = 2'd0;
    cfg_valid = 1'b1;
    tick(3);
    cfg_valid = 1'b0;
    tick(5);
    edge_exp(2'd2, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd2, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd2, 1'b0, 1'b0, 1'b1);

    // Vsync stops with a request for mode 0 pending
    push(2'd2, 1'b0, 1'b1, 1'b0, fc, 1'b0);
    req(2'd0);
`ifdef ISP_MODE_CTRL_TIMEOUT_EN
    push(2'd2, 1'b0, 1'b1, 1'b0, fc, 1'b1);
    push(2'd0, 1'b1, 1'b1, 1'b0, fc, 1'b1);
    tick(1300);
    edge_exp(2'd0, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd0, 1'b0, 1'b0, 1'b1);
`else
    tick(1300);
    edge_exp(2'd0, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd0, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd0, 1'b0, 1'b0, 1'b1);
`endif

    // Reset in the middle of a flush
    push(2'd0, 1'b0, 1'b1, 1'b0, fc, 1'b0);
    req(2'd1);
    tick(5);
    edge_exp(2'd1, 1'b1, 1'b1, 1'b0);
    push(2'd3, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    fc = 16'd0;
    tick(3);
    edge_exp(2'd3, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd3, 1'b0, 1'b0, 1'b1);

    // Reset while a request is pending: the request is discarded
    push(2'd3, 1'b0, 1'b1, 1'b0, fc, 1'b0);
    req(2'd0);
    tick(3);
    push(2'd3, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    fc = 16'd0;
    tick(3);
    edge_exp(2'd3, 1'b1, 1'b1, 1'b0);
    edge_exp(2'd3, 1'b0, 1'b0, 1'b1);

    // Frame counter wrap from a preloaded 0xFFFF
    push(2'd3, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    dut.r_frame_cnt = 16'hFFFF;
    fc = 16'hFFFF;
    tick(3);
    edge_exp(2'd3, 1'b0, 1'b0, 1'b1);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected output changes never seen, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isp_mode_ctrl.md
# isp_mode_ctrl

Frame-synchronous controller for the HDMI output ISP path. It decides which processing stage drives the HDMI transmitter: bypass, or one of three demosaic variants (high/medium/low cost). A mode change requested from the control side is applied only on a vsync rising edge. The output is then muted for a programmable number of whole frames while the newly selected stage's line buffers refill. It also keeps a free-running frame counter and an optional vsync-loss watchdog.

## Interface
- `RESET_MODE`, default 3. Mode applied out of reset: 0 bypass, 1 demosaic_h, 2 demosaic_m, 3 demosaic_l.
- `FLUSH_FRAMES`, default 2. Whole frames muted after each mode switch and after reset. Legal range 1..15.
- `TIMEOUT_CYCLES`, default 3000000. Vsync watchdog limit in pixel_clk cycles; must be less than 2^22.
- `pixel_clk`, in, 1. Pixel clock; the only clock.
- `sys_rst_n`, in, 1. Asynchronous, active-low reset.
- `in_vsync`, in, 1. Active-high vsync from the video timing generator, synchronous to pixel_clk.
- `cfg_mode`, in, 2. Requested mode.
- `cfg_valid`, in, 1. Request strobe.
- `cfg_ready`, out, 1. Controller can accept a request.
- `act_mode`, out, 2. Applied mode; drives the output mux select.
- `stage_en`, out, 4. One-hot of `act_mode`: bit0 bypass, bit1 h, bit2 m, bit3 l.
- `mute`, out, 1. Force HDMI RGB to black.
- `busy`, out, 1. High whenever the state is not RUN.
- `frame_cnt`, out, 16. Count of vsync rising edges.
- `vs_timeout`, out, 1. Vsync-loss flag.

## Operation
- **Edge detect:** `vs_d` holds `in_vsync` registered. `vs_rise` = `in_vsync & ~vs_d`.
- **States:** RUN, PEND, FLUSH. A 4-bit `flush_cnt` and a 2-bit `pend_mode` back the FSM.
- **RUN:**
  - `cfg_ready`=1.
  - On `cfg_valid & cfg_ready` with `cfg_mode == act_mode`: the request is accepted and the state stays RUN.
  - On `cfg_valid & cfg_ready` otherwise: `pend_mode`<=`cfg_mode` and the state goes to PEND.
- **PEND:**
  - `cfg_ready`=0; `cfg_valid` is ignored.
  - On `vs_rise`, or when `vs_timeout`=1 (no video, so no tearing): `act_mode`<=`pend_mode`, `stage_en` is updated, `mute`<=1, `flush_cnt`<=`FLUSH_FRAMES`, and the state goes to FLUSH.
- **FLUSH:**
  - `cfg_ready`=0 and `mute`=1.
  - Each `vs_rise` decrements `flush_cnt`.
  - On the `vs_rise` where `flush_cnt`==1: `mute`<=0, the state goes to RUN, and `cfg_ready`<=1.
  - The result is that exactly `FLUSH_FRAMES` complete frames are muted after the switch edge.
  - `vs_timeout` does not release FLUSH.
- **frame_cnt:** +1 on every `vs_rise`, in every state. Wraps from 0xFFFF to 0.
- **Watchdog:** a 22-bit counter clears on `vs_rise` and otherwise increments, saturating at `TIMEOUT_CYCLES-1`. Reaching `TIMEOUT_CYCLES-1` sets `vs_timeout`. `vs_timeout` stays set until the next `vs_rise`, which clears it.

## Timing
- **Reset values:**
  - state=FLUSH, `flush_cnt`=`FLUSH_FRAMES`
  - `act_mode`=`RESET_MODE`, `stage_en`=one-hot(`RESET_MODE`)
  - `mute`=1, `busy`=1, `cfg_ready`=0
  - `frame_cnt`=0, `vs_timeout`=0, `vs_d`=0, `pend_mode`=`RESET_MODE`
- All outputs are registered.
- **Latency:**
  - If `in_vsync` is first sampled high in cycle N, changes to `act_mode`, `stage_en`, `mute` and `frame_cnt` are visible in cycle N+1.
  - A request accepted in cycle N gives `cfg_ready`=0 and `busy`=1 in cycle N+1.
- **Request coincident with an edge:** a request accepted in the same cycle as a `vs_rise` in RUN does not use that edge. It waits for the next `vs_rise`.
- **Watchdog timing:** `vs_timeout` rises on the cycle after the counter value `TIMEOUT_CYCLES-1` is registered. A PEND state waiting on it applies the mode one cycle after `vs_timeout` is seen.
- **Vsync held high:** this produces only one `vs_rise`.
- **Reset mid-operation:** the reset asynchronously forces all reset values, and any pending request is discarded.

## Configuration
- **`ISP_MODE_CTRL_TIMEOUT_EN` defined:** the watchdog counter and `vs_timeout` are built as described.
- **`ISP_MODE_CTRL_TIMEOUT_EN` undefined:** no counter is built, `vs_timeout` is tied to 0, and PEND waits for `vs_rise` indefinitely.

## Test plan
- **Reset and flush release:** reset with `FLUSH_FRAMES`=2 -> `mute`=1, `act_mode`=3, `stage_en`=4'b1000. After the 2nd `vs_rise`, `mute`=0, `cfg_ready`=1, `frame_cnt`=2.
- **Mode switch:** in RUN, request `cfg_mode`=1 mid-frame -> `act_mode` stays 3 until the next `vs_rise`. Then `act_mode`=1, `stage_en`=4'b0010, `mute`=1 for 2 frames, and `busy` falls together with `mute`.
- **Same-mode request:** request `cfg_mode`=`act_mode` -> no state change, `busy` stays 0, `mute` stays 0.
- **Request on an edge:** request coincident with `vs_rise` -> the switch occurs at the following `vs_rise`. A second `cfg_valid` during PEND is ignored, and the first request's mode is applied.
- **Watchdog (macro on, `TIMEOUT_CYCLES`=1000):** stop vsync, then request mode 0 -> `vs_timeout`=1 about 1000 cycles after the last edge. PEND applies `act_mode`=0 the cycle after that. FLUSH holds `mute`=1 until vsync resumes, and the first `vs_rise` clears `vs_timeout`.
- **Reset mid-operation and counter wrap:** assert reset mid-FLUSH -> all reset values return. Preload the bench to `frame_cnt`=0xFFFF -> the next `vs_rise` gives 0x0000.
